// File: rtl/ilm_iter_sched_pkg.sv
// Shared types and constants for the iterative logarithmic-multiplier scheduler.
package ilm_iter_sched_pkg;

    localparam int ITER_W       = 3;
    localparam int DEF_MAX_ITER = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ilm_state_e;

    // Zero requests still run one iteration; anything above the cap is trimmed.
    function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] req,
                                                     input logic [ITER_W-1:0] max_it);
        if (req == '0)
            return {{(ITER_W-1){1'b0}}, 1'b1};
        else if (req > max_it)
            return max_it;
        else
            return req;
    endfunction

endpackage

// File: rtl/ilm_iter_sched_stage.sv
// One Mitchell-style iteration: leading-one split of both operands and partial product.
module ilm_stage
    import ilm_iter_sched_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]   u,
    input  logic [N-1:0]   v,
    output logic [2*N-1:0] p,
    output logic [N-1:0]   u1,
    output logic [N-1:0]   v1
);

    localparam int KW = $clog2(N);

    logic [KW-1:0]  k_u;
    logic [KW-1:0]  k_v;
    logic [KW:0]    k_sum;
    logic [N-1:0]   mask_u;
    logic [N-1:0]   mask_v;
    logic [2*N-1:0] one_w;
    logic [2*N-1:0] u1_w;
    logic [2*N-1:0] v1_w;

    always_comb begin
        k_u = '0;
        k_v = '0;
        for (int i = 0; i < N; i++) begin
            if (u[i]) k_u = i[KW-1:0];
            if (v[i]) k_v = i[KW-1:0];
        end
    end

    always_comb begin
        mask_u = {{(N-1){1'b0}}, 1'b1} << k_u;
        mask_v = {{(N-1){1'b0}}, 1'b1} << k_v;
        u1     = u & ~mask_u;
        v1     = v & ~mask_v;
        k_sum  = {1'b0, k_u} + {1'b0, k_v};
        one_w  = {{(2*N-1){1'b0}}, 1'b1};
        u1_w   = {{N{1'b0}}, u1};
        v1_w   = {{N{1'b0}}, v1};
        // A zero operand has no leading one, so its product contribution is zero.
        if (u == '0 || v == '0)
            p = '0;
        else
            p = (one_w << k_sum) + (u1_w << k_v) + (v1_w << k_u);
    end

endmodule

// File: rtl/ilm_iter_sched.sv
// Iterative approximate multiplier scheduler: one ilm_stage reused once per RUN cycle.
//   state   | meaning
//   IDLE    | ready for a request, operands latched on in_valid
//   RUN     | one iteration per cycle into the saturating accumulator
//   DONE    | result presented until out_ready
module ilm_iter_sched
    import ilm_iter_sched_pkg::*;
#(
    parameter int N        = 16,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_a,
    input  logic [N-1:0]      in_b,
    input  logic [ITER_W-1:0] in_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    out_result,
    output logic [ITER_W-1:0] out_iter_used,
    output logic              busy
);

    localparam logic [ITER_W-1:0] MAX_IT_W = ITER_W'(MAX_ITER);

    ilm_state_e        state_q, state_d;
    logic [N-1:0]      u_q, u_d, v_q, v_d;
    logic [2*N-1:0]    acc_q, acc_d;
    logic [ITER_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;

    logic [2*N-1:0]    p;
    logic [N-1:0]      u1, v1;
    logic [2*N:0]      sum;
    logic [ITER_W-1:0] cnt_inc;

    ilm_stage #(.N(N)) u_stage (
        .u  (u_q),
        .v  (v_q),
        .p  (p),
        .u1 (u1),
        .v1 (v1)
    );

    assign sum     = {1'b0, acc_q} + {1'b0, p};
    assign cnt_inc = cnt_q + {{(ITER_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            // Stop as soon as either remainder is zero: later products would all be zero.
            ST_RUN:  if (cnt_inc == tgt_q || u1 == '0 || v1 == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        u_d   = u_q;
        v_d   = v_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        if (state_q == ST_IDLE && in_valid) begin
            u_d   = in_a;
            v_d   = in_b;
            acc_d = '0;
            cnt_d = '0;
            tgt_d = clamp_iter(in_iter, MAX_IT_W);
        end else if (state_q == ST_RUN) begin
            u_d   = u1;
            v_d   = v1;
            acc_d = sum[2*N] ? {(2*N){1'b1}} : sum[2*N-1:0];
            cnt_d = cnt_inc;
        end
    end

    always_comb begin
        in_ready      = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        out_valid     = (state_q == ST_DONE);
        out_result    = acc_q;
        out_iter_used = cnt_q;
    end

endmodule

// File: tb/tb_ilm_iter_sched.sv
// Self-checking bench for ilm_iter_sched: directed cases, backpressure, reset abort, random ops.
module tb_ilm_iter_sched;

    localparam int N        = 16;
    localparam int MAX_ITER = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_a = '0;
    logic [N-1:0]  in_b = '0;
    logic [2:0]    in_iter = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*N-1:0] out_result;
    logic [2:0]    out_iter_used;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    ilm_iter_sched #(.N(N), .MAX_ITER(MAX_ITER)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_iter       (in_iter),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_iter_used (out_iter_used),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic int msb_pos(input longint unsigned x);
        int k = 0;
        for (int i = 0; i < 64; i++) if (x >= (64'd1 << i)) k = i;
        return k;
    endfunction

    // Each step removes the exact product minus the neglected u1*v1 term.
    task automatic model(input longint unsigned a, input longint unsigned b, input int it,
                         output longint unsigned res, output int used);
        longint unsigned u = a, v = b, u1, v1, p, acc = 0;
        longint unsigned sat = (64'd1 << (2*N)) - 1;
        int tgt = (it == 0) ? 1 : (it > MAX_ITER ? MAX_ITER : it);
        int n = 0;
        do begin
            if (u == 0 || v == 0) begin
                p = 0; u1 = 0; v1 = 0;
            end else begin
                u1 = u - (64'd1 << msb_pos(u));
                v1 = v - (64'd1 << msb_pos(v));
                p  = u * v - u1 * v1;
            end
            acc = (acc + p > sat) ? sat : acc + p;
            n++;
            u = u1; v = v1;
        end while (n < tgt && u != 0 && v != 0);
        res = acc; used = n;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] it,
                         input int hold, output logic [2*N-1:0] res, output logic [2:0] used,
                         output int lat, output bit got, output bit stable);
        @(negedge clk);
        in_a = a; in_b = b; in_iter = it; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = out_valid; res = out_result; used = out_iter_used; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!out_valid || out_result !== res || out_iter_used !== used) stable = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_result !== '0 || out_iter_used !== 3'd0) begin
            n_bad++;
            $display("FAIL reset: v/r/b=%b res=%0d used=%0d, want 010 0 0",
                     {out_valid, in_ready, busy}, out_result, out_iter_used);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [6] = '{16'd3, 16'd3, 16'd15, 16'd15, 16'd0, 16'd16};
        logic [N-1:0] tb [6] = '{16'd3, 16'd3, 16'd15, 16'd15, 16'd5, 16'd3};
        logic [2:0]   ti [6] = '{3'd1, 3'd4, 3'd4, 3'd2, 3'd3, 3'd4};
        longint unsigned er [6] = '{8, 9, 225, 216, 0, 48};
        int           eu [6] = '{1, 2, 4, 2, 1, 1};
        logic [2*N-1:0] res; logic [2:0] used; int lat; bit got, st;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ti[i], 0, res, used, lat, got, st);
            n_cmp++;
            if (!got || res !== er[i][2*N-1:0] || used !== eu[i][2:0] || lat != eu[i]) begin
                n_bad++;
                $display("FAIL directed%0d: got=%0b res=%0d used=%0d lat=%0d, want res=%0d used=%0d lat=%0d",
                         i, got, res, used, lat, er[i], eu[i], eu[i]);
            end
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL directed%0d_release: valid=%b ready=%b, want 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2*N-1:0] first;
        int lat = 0;
        bit ok = 1'b1;
        @(negedge clk);
        in_a = 16'd15; in_b = 16'd15; in_iter = 3'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        first = out_result;
        in_a = 16'd3; in_b = 16'd3; in_iter = 3'd1; in_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            if (!out_valid || out_result !== first || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        n_cmp++;
        if (!ok || first !== 32'd225) begin
            n_bad++;
            $display("FAIL backpressure_hold: stable=%0b res=%0d, want 1 225", ok, first);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_xfer: v/r/b=%b, want 010", {out_valid, in_ready, busy});
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure_no_reaccept: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*N-1:0] res; logic [2:0] used; int lat; bit got, st;
        @(negedge clk);
        in_a = 16'd15; in_b = 16'd15; in_iter = 3'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_result !== '0 || out_iter_used !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: v/r/b=%b res=%0d used=%0d, want 010 0 0",
                     {out_valid, in_ready, busy}, out_result, out_iter_used);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'd3, 16'd3, 3'd4, 0, res, used, lat, got, st);
        n_cmp++;
        if (!got || res !== 32'd9 || used !== 3'd2) begin
            n_bad++;
            $display("FAIL after_reset: got=%0b res=%0d used=%0d, want 9 2", got, res, used);
        end
    endtask

    task automatic test_random();
        logic [2*N-1:0] res; logic [2:0] used; int lat; bit got, st;
        longint unsigned er; int eu;
        logic [N-1:0] a, b; logic [2:0] it;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = '0;
                1: a = N'($urandom_range(1, 15));
                default: a = N'($urandom);
            endcase
            b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            it = 3'($urandom_range(0, 7));
            model(longint'(a), longint'(b), int'(it), er, eu);
            do_op(a, b, it, $urandom_range(0, 3), res, used, lat, got, st);
            n_cmp++;
            if (!got || !st || res !== er[2*N-1:0] || used !== eu[2:0] || lat != eu) begin
                n_bad++;
                $display("FAIL random%0d a=%0d b=%0d it=%0d: got=%0b stable=%0b res=%0d used=%0d lat=%0d, want res=%0d used=%0d",
                         i, a, b, it, got, st, res, used, lat, er, eu);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
